// File: rtl/dcpu16_regfile.sv
// DCPU16 general-purpose register file: two registered read ports, one write
// port with optional write-first forwarding, stall enable and a clear sequencer.
module dcpu16_regfile #(
  parameter int DW     = 16,
  parameter int AW     = 3,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          rwe,
  input  logic [AW-1:0] rwa,
  input  logic [DW-1:0] rwd,
  input  logic [AW-1:0] rra0,
  input  logic [AW-1:0] rra1,
  output logic [DW-1:0] rrd0,
  output logic [DW-1:0] rrd1,
  output logic          busy
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic [DW-1:0] r_rrd0;
  logic [DW-1:0] r_rrd1;
  logic [DW-1:0] r_file [DEPTH];

  logic          w_clearing;
  logic          w_user_we;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_wa;
  logic [DW-1:0] w_mem_wd;
  logic          w_fwd0;
  logic          w_fwd1;

  // The array has a single write port shared by the clear sequencer and the
  // user; reset itself also zeroes entry 0 so the sequence restarts cleanly.
  assign w_clearing = rst || (r_state == CLR);
  assign w_user_we  = (r_state == RUN) && ena && rwe;
  assign w_mem_we   = w_clearing || w_user_we;
  assign w_mem_wa   = rst ? '0 : ((r_state == CLR) ? r_cnt : rwa);
  assign w_mem_wd   = w_clearing ? '0 : rwd;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_file[w_mem_wa] <= w_mem_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_fwd0 = BYPASS && rwe && (rwa == rra0);
  assign w_fwd1 = BYPASS && rwe && (rwa == rra1);

  // Outputs are forced to zero while clearing so no stale contents leak out.
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_rrd0 <= '0;
      r_rrd1 <= '0;
    end else if (ena) begin
      r_rrd0 <= w_fwd0 ? rwd : r_file[rra0];
      r_rrd1 <= w_fwd1 ? rwd : r_file[rra1];
    end
  end

  assign rrd0 = r_rrd0;
  assign rrd1 = r_rrd1;
  assign busy = r_busy;

endmodule

// File: tb/tb_dcpu16_regfile.sv
// Directed + random bench for dcpu16_regfile: checks a BYPASS=1 and a BYPASS=0
// instance side by side against a scoreboard of expected outputs.
module tb_dcpu16_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic        rwe = 1'b0;
  logic [2:0]  rwa = '0;
  logic [15:0] rwd = '0;
  logic [2:0]  rra0 = '0;
  logic [2:0]  rra1 = '0;
  logic [15:0] rrd0_b, rrd1_b, rrd0_n, rrd1_n;
  logic        busy_b, busy_n;

  always #5 clk = ~clk;

  dcpu16_regfile #(.DW(16), .AW(3), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .ena(ena), .rwe(rwe), .rwa(rwa), .rwd(rwd),
    .rra0(rra0), .rra1(rra1), .rrd0(rrd0_b), .rrd1(rrd1_b), .busy(busy_b)
  );

  dcpu16_regfile #(.DW(16), .AW(3), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .ena(ena), .rwe(rwe), .rwa(rwa), .rwd(rwd),
    .rra0(rra0), .rra1(rra1), .rrd0(rrd0_n), .rrd1(rrd1_n), .busy(busy_n)
  );

  typedef struct {
    logic [15:0] b0;
    logic [15:0] b1;
    logic [15:0] n0;
    logic [15:0] n1;
    logic        bsy;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_e;
  logic [15:0] mem [8];
  int          clr_left;
  int          n_pass;
  int          n_total;
  int          n_fail;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Computes the expected post-edge outputs from the current inputs, queues
  // them, advances one clock and compares against what both DUTs produced.
  task automatic cycle();
    exp_t e;
    e = last_e;
    if (rst) begin
      clr_left = 8;
      e.b0 = '0; e.b1 = '0; e.n0 = '0; e.n1 = '0; e.bsy = 1'b1;
    end else if (clr_left > 0) begin
      clr_left--;
      e.b0 = '0; e.b1 = '0; e.n0 = '0; e.n1 = '0;
      e.bsy = (clr_left != 0);
      if (clr_left == 0) begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
      end
    end else if (ena) begin
      e.n0  = mem[rra0];
      e.n1  = mem[rra1];
      e.b0  = (rwe && rwa == rra0) ? rwd : mem[rra0];
      e.b1  = (rwe && rwa == rra1) ? rwd : mem[rra1];
      e.bsy = 1'b0;
      if (rwe) mem[rwa] = rwd;
    end
    sb_q.push_back(e);
    last_e = e;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("t=%0t rst=%0b ena=%0b rwe=%0b rwa=%0d rwd=%h rra=%0d/%0d -> byp %h/%h nob %h/%h busy %0b",
             $time, rst, ena, rwe, rwa, rwd, rra0, rra1, rrd0_b, rrd1_b, rrd0_n, rrd1_n, busy_b);
    check("busy_byp", {15'd0, busy_b}, {15'd0, e.bsy});
    check("busy_nob", {15'd0, busy_n}, {15'd0, e.bsy});
    check("rrd0_byp", rrd0_b, e.b0);
    check("rrd1_byp", rrd1_b, e.b1);
    check("rrd0_nob", rrd0_n, e.n0);
    check("rrd1_nob", rrd1_n, e.n1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    rwe = 1'b1; rwa = a; rwd = d;
    cycle();
    rwe = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
    rra0 = a0; rra1 = a1;
    cycle();
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(7 - i));
      check(tag, rrd0_b | rrd1_b | rrd0_n | rrd1_n, 16'h0000);
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0; clr_left = 0;
    last_e = '{16'h0, 16'h0, 16'h0, 16'h0, 1'b1};
    for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;

    // 1: clear with rwe held high throughout
    rst = 1'b1; rwe = 1'b1; rwd = 16'hFFFF;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rwa = 3'(i);
      cycle();
      check("clr_busy_directed", {15'd0, busy_b}, (i < 7) ? 16'd1 : 16'd0);
    end
    rwe = 1'b0;
    read_all_zero("clr_readback");

    // 2: basic write/read
    wr(3'd2, 16'h1234);
    wr(3'd7, 16'hBEEF);
    rd(3'd2, 3'd7);
    check("basic_rrd0", rrd0_b, 16'h1234);
    check("basic_rrd1", rrd1_b, 16'hBEEF);

    // 3: forwarding on both ports at once
    wr(3'd3, 16'h0001);
    rwe = 1'b1; rwa = 3'd3; rwd = 16'hA5A5;
    rd(3'd3, 3'd3);
    rwe = 1'b0;
    check("fwd_byp_rrd0", rrd0_b, 16'hA5A5);
    check("fwd_byp_rrd1", rrd1_b, 16'hA5A5);
    check("fwd_nob_rrd0", rrd0_n, 16'h0001);
    rd(3'd3, 3'd3);
    check("fwd_nob_reread", rrd1_n, 16'hA5A5);

    // 4: stall suppresses writes and holds outputs
    rd(3'd2, 3'd2);
    ena = 1'b0; rwe = 1'b1; rwa = 3'd2; rwd = 16'hFFFF; rra0 = 3'd5;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_hold", rrd0_b, 16'h1234);
    end
    ena = 1'b1; rwe = 1'b0;
    rd(3'd2, 3'd5);
    check("stall_no_write", rrd0_n, 16'h1234);

    // 5: reset asserted on the 4th clear cycle
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    check("midclr_busy_done", {15'd0, busy_n}, 16'd0);
    read_all_zero("midclr_readback");

    // 6: reset during RUN with all entries loaded
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1111 * 16'(i + 1));
    rd(3'd7, 3'd0);
    check("load_rrd0", rrd0_b, 16'h8888);
    rst = 1'b1;
    cycle();
    check("runrst_busy", {15'd0, busy_b}, 16'd1);
    check("runrst_rrd", rrd0_b | rrd1_b, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    read_all_zero("runrst_readback");

    // Random traffic with stalls and collisions
    for (int i = 0; i < 80; i++) begin
      ena  = ($urandom_range(0, 3) != 0);
      rwe  = $urandom_range(0, 1) == 1;
      rwa  = 3'($urandom_range(0, 7));
      rwd  = 16'($urandom);
      rra0 = ($urandom_range(0, 2) == 0) ? rwa : 3'($urandom_range(0, 7));
      rra1 = ($urandom_range(0, 2) == 0) ? rwa : 3'($urandom_range(0, 7));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
